// File: rtl/clk_tick_rx_if.sv
// Bundle carrying the received clock level and the tick/period results of clk_tick_rx.
// The master modport is the receiver itself; the slave modport is the consumer side
// (game logic or a bench) that supplies clk_in and reads the results.
//
// Signal contract: tick_rise and tick_fall are single-cycle enables in the clk domain,
// never both high in the same cycle. period is meaningful only while period_valid is 1.
// The outputs have no backpressure: a consumer that misses a tick cannot get it back.
interface clk_tick_rx_if #(
  parameter int PERIOD_W = 24
) ();
  logic                clk_in;
  logic                tick_rise;
  logic                tick_fall;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stalled;
  logic [1:0]          fsm_state;

  modport master (
    input  clk_in,
    output tick_rise,
    output tick_fall,
    output period,
    output period_valid,
    output stalled,
    output fsm_state
  );

  modport slave (
    output clk_in,
    input  tick_rise,
    input  tick_fall,
    input  period,
    input  period_valid,
    input  stalled,
    input  fsm_state
  );
endinterface

// File: rtl/clk_tick_rx.sv
// clk_tick_rx: brings a slow/asynchronous clock level into the clk domain, turns its
// edges into one-cycle tick enables, measures the rising-edge period in clk cycles and
// flags a stalled input with a watchdog.
// Optional build macro CLK_TICK_RX_GLITCH_FILTER_EN inserts a stability filter between
// the synchronizer and the edge detector (FILTER_LEN consecutive samples required).
// fsm_state encoding: 0 = ACQUIRE, 1 = MEASURE, 2 = STALLED.
module clk_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 24,
  parameter int TIMEOUT     = 1000000,
  parameter int FILTER_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  clk_tick_rx_if.master bus
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(TIMEOUT - 1);
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

  // Elaboration-time parameter range guards.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("clk_tick_rx: SYNC_STAGES must be 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $error("clk_tick_rx: FILTER_LEN must be 1..15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("clk_tick_rx: TIMEOUT must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   lvl;
  logic                   lvl_prev_q;
  logic                   rise_ev;
  logic                   fall_ev;
  logic                   tick_rise_q;
  logic                   tick_fall_q;

  state_t                 state_q;
  state_t                 state_d;
  logic [PERIOD_W-1:0]    cnt_q;
  logic [PERIOD_W-1:0]    cnt_d;
  logic [PERIOD_W-1:0]    period_q;
  logic [PERIOD_W-1:0]    period_d;
  logic                   valid_q;
  logic                   valid_d;
  logic                   stalled_q;
  logic                   stalled_d;

  // Shift the raw level through the synchronizer chain; bit 0 is the first sampling flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CLK_TICK_RX_GLITCH_FILTER_EN
  localparam logic [3:0] STAB_LAST = 4'(FILTER_LEN - 1);

  logic       filt_q;
  logic [3:0] stab_q;

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync_out != filt_q) begin
      if (stab_q == STAB_LAST) begin
        filt_q <= sync_out;
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + 4'd1;
      end
    end else begin
      stab_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_out;
`endif

  // The previous level resets to 0, so a high input at reset release reads as a rising edge.
  assign rise_ev = lvl & ~lvl_prev_q;
  assign fall_ev = ~lvl & lvl_prev_q;

  // Register the level history and the one-cycle tick enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_prev_q  <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
    end else begin
      lvl_prev_q  <= lvl;
      tick_rise_q <= rise_ev;
      tick_fall_q <= fall_ev;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQUIRE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter/period/watchdog updates; a rising edge in the cycle the
  // counter hits its last value wins over the stall and yields period == TIMEOUT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    period_d  = period_q;
    valid_d   = valid_q;
    stalled_d = stalled_q;
    case (state_q)
      ACQUIRE: begin
        if (rise_ev) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // No watchdog before the first edge; just keep the counter from wrapping.
          cnt_d = cnt_q;
        end
      end
      MEASURE: begin
        if (rise_ev) begin
          cnt_d    = '0;
          period_d = cnt_q + CNT_ONE;
          valid_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = cnt_q;
          stalled_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = STALLED;
        end
      end
      STALLED: begin
        cnt_d = cnt_q;
        if (rise_ev) begin
          cnt_d     = '0;
          stalled_d = 1'b0;
          state_d   = MEASURE;
        end
      end
      default: begin
        state_d = ACQUIRE;
        cnt_d   = '0;
      end
    endcase
  end

  // Measurement and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign bus.tick_rise    = tick_rise_q;
  assign bus.tick_fall    = tick_fall_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.stalled      = stalled_q;
  assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_clk_tick_rx.sv
// Bench for clk_tick_rx: one receiver with TIMEOUT=20 and one with TIMEOUT=16 share the
// same clk_in stimulus. Edge index k below means the k-th posedge that samples clk_in
// after the stimulus starts; outputs are read 1 ns after that edge.
module tb_clk_tick_rx;
  localparam int PW = 24;
`ifdef CLK_TICK_RX_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_in = 1'b0;

  clk_tick_rx_if #(.PERIOD_W(PW)) if20 ();
  clk_tick_rx_if #(.PERIOD_W(PW)) if16 ();

  assign if20.clk_in = clk_in;
  assign if16.clk_in = clk_in;

  clk_tick_rx #(.SYNC_STAGES(2), .PERIOD_W(PW), .TIMEOUT(20), .FILTER_LEN(4)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (if20)
  );

  clk_tick_rx #(.SYNC_STAGES(2), .PERIOD_W(PW), .TIMEOUT(16), .FILTER_LEN(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  typedef struct {
    logic          in;
    logic          rise;
    logic          fall;
    logic [PW-1:0] period;
    logic          valid;
  } vec_t;

  vec_t        vecs[12];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},    if20.tick_rise,    0);
    check({tag, "_fall"},    if20.tick_fall,    0);
    check({tag, "_period"},  if20.period,       0);
    check({tag, "_valid"},   if20.period_valid, 0);
    check({tag, "_stalled"}, if20.stalled,      0);
    check({tag, "_state"},   if20.fsm_state,    0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    clk_in = 1'b0;
    step();
    step();
    check_all_zero("reset");
    check("reset_state16", if16.fsm_state, 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int k_a;
    int k_b;
    int nr;
    int nf;
    int last_rise;
    int first_stall;
    logic early;
    logic any_stall;

`ifndef CLK_TICK_RX_GLITCH_FILTER_EN
    // Divide-by-4 input: {clk_in, tick_rise, tick_fall, period, period_valid}.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 24'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 24'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 24'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 24'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'd4, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'd4, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 24'd4, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 24'd4, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 24'd4, 1'b1};

    // Test 1: table-driven divide-by-4.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      clk_in = vecs[i].in;
      step();
      check($sformatf("t1[%0d].rise", i),    if20.tick_rise,    vecs[i].rise);
      check($sformatf("t1[%0d].fall", i),    if20.tick_fall,    vecs[i].fall);
      check($sformatf("t1[%0d].period", i),  if20.period,       vecs[i].period);
      check($sformatf("t1[%0d].valid", i),   if20.period_valid, vecs[i].valid);
      check($sformatf("t1[%0d].stalled", i), if20.stalled,      0);
    end
`endif

    // Test 2: three periods of 8, then held low until the watchdog fires (TIMEOUT=20).
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(LAT + 8 * i));
    last_rise   = 0;
    first_stall = 0;
    for (int k = 1; k <= 70; k++) begin
      clk_in = (k <= 24) && (((k - 1) % 8) < 4);
      step();
      if (if20.tick_rise) begin
        last_rise = k;
        if (exp_q.size() == 0) check("t2_extra_rise", k, 0);
        else check("t2_rise_cycle", k, exp_q.pop_front());
      end
      if (if20.stalled && first_stall == 0) begin
        first_stall = k;
        check("t2_period_at_stall", if20.period, 8);
        check("t2_valid_at_stall", if20.period_valid, 0);
        check("t2_state_stalled", if20.fsm_state, 2);
      end
    end
    check("t2_missing_rise", exp_q.size(), 0);
    check("t2_stall_delay", first_stall - last_rise, 20);
    check("t2_stall_held", if20.stalled, 1);
    check("t2_period_held", if20.period, 8);

    // Test 2 restart: period 10 input; valid only after one full period.
    n     = 0;
    early = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      clk_in = ((k - 1) % 10) < 5;
      step();
      if (if20.tick_rise) begin
        n++;
        if (n == 1) begin
          check("t2r_stalled_clear", if20.stalled, 0);
          check("t2r_valid_low", if20.period_valid, 0);
          check("t2r_period_kept", if20.period, 8);
          check("t2r_state_measure", if20.fsm_state, 1);
        end
        if (n == 2) begin
          check("t2r_period_new", if20.period, 10);
          check("t2r_valid_new", if20.period_valid, 1);
        end
      end else if (n == 1 && if20.period_valid) begin
        early = 1'b1;
      end
    end
    check("t2r_rise_count", n, 3);
    check("t2r_valid_early", early, 0);

    // Test 3: period 16 lands the rising tick on cnt==15 of the TIMEOUT=16 receiver.
    do_reset();
    n         = 0;
    any_stall = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      clk_in = ((k - 1) % 16) < 8;
      step();
      if (if16.stalled) any_stall = 1'b1;
      if (if16.tick_rise) begin
        n++;
        if (n == 2) begin
          check("t3_rise2_cycle", k, LAT + 16);
          check("t3_period", if16.period, 16);
          check("t3_valid", if16.period_valid, 1);
        end
      end
    end
    check("t3_rise_count", n, 3);
    check("t3_no_stall", any_stall, 0);

    // Test 3b: period 17 is one cycle too long for TIMEOUT=16 and must stall.
    do_reset();
    first_stall = 0;
    for (int k = 1; k <= 26; k++) begin
      clk_in = ((k - 1) % 17) < 9;
      step();
      if (if16.stalled && first_stall == 0) first_stall = k;
    end
    check("t3b_stall_cycle", first_stall, LAT + 16);
    check("t3b_stall_cleared", if16.stalled, 0);
    check("t3b_valid_low", if16.period_valid, 0);

    // Test 4: clk_in high through reset, then a mid-period reset.
    rst    = 1'b1;
    clk_in = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= LAT + 11; k++) begin
      clk_in = ((k - 1) % 8) < 4;
      step();
      if (k <= LAT) check($sformatf("t4_rise_k%0d", k), if20.tick_rise, (k == LAT) ? 1 : 0);
      if (k == LAT) begin
        check("t4_state_measure", if20.fsm_state, 1);
        check("t4_valid_low", if20.period_valid, 0);
      end
      if (k == LAT + 8) begin
        check("t4_rise2", if20.tick_rise, 1);
        check("t4_period", if20.period, 8);
        check("t4_valid", if20.period_valid, 1);
      end
    end
    rst = 1'b1;
    step();
    check_all_zero("t4_midreset");
    rst = 1'b0;

`ifdef CLK_TICK_RX_GLITCH_FILTER_EN
    // Test 5: 2-cycle glitch is filtered; 6-cycle pulse passes.
    do_reset();
    nr = 0;
    nf = 0;
    for (int k = 1; k <= 14; k++) begin
      clk_in = (k <= 2);
      step();
      if (if20.tick_rise) nr++;
      if (if20.tick_fall) nf++;
    end
    check("t5_glitch_rise", nr, 0);
    check("t5_glitch_fall", nf, 0);
    do_reset();
    nr  = 0;
    nf  = 0;
    k_a = 0;
    k_b = 0;
    for (int k = 1; k <= 20; k++) begin
      clk_in = (k <= 6);
      step();
      if (if20.tick_rise) begin nr++; k_a = k; end
      if (if20.tick_fall) begin nf++; k_b = k; end
    end
    check("t5_pulse_rise_count", nr, 1);
    check("t5_pulse_fall_count", nf, 1);
    check("t5_pulse_rise_cycle", k_a, 7);
    check("t5_pulse_fall_cycle", k_b, 13);
`else
    // Test 6: unfiltered 2-cycle glitch gives one rise and one fall, 2 cycles apart.
    do_reset();
    nr  = 0;
    nf  = 0;
    k_a = 0;
    k_b = 0;
    for (int k = 1; k <= 12; k++) begin
      clk_in = (k <= 2);
      step();
      if (if20.tick_rise) begin nr++; k_a = k; end
      if (if20.tick_fall) begin nf++; k_b = k; end
    end
    check("t6_rise_count", nr, 1);
    check("t6_fall_count", nf, 1);
    check("t6_rise_cycle", k_a, 3);
    check("t6_fall_cycle", k_b, 5);
`endif

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
